// File: rtl/maxpool_scheduler.sv
// ---------------------------------------------------------------------------
// maxpool_scheduler
//
// Walks a D x H x W feature map stored in a single-port SRAM (1-cycle read
// latency) and performs 2x2 / stride-2 max pooling. Every pooling window is
// read with four SRAM reads. A running signed maximum is kept, and one pooled
// word per window is emitted on a valid/ready stream. Odd row and column
// counts are floored: the trailing row or column is never read.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset; aborts a pass with no done
//   start      in   begin a full layer pass; only looked at while idle
//   busy       out  high from the cycle after an accepted start through done
//   done       out  one-cycle pulse after the last output handshake
//   rd_en      out  SRAM read strobe
//   rd_addr    out  SRAM read address, (c*H + row)*W + col
//   rd_data    in   SRAM read data, valid the cycle after rd_en
//   out_valid  out  pooled word available
//   out_ready  in   downstream accepts the pooled word
//   out_data   out  pooled maximum (signed)
//   out_addr   out  pooled index, (c*(H/2) + r/2)*(W/2) + x/2
// ---------------------------------------------------------------------------
module maxpool_scheduler #(
  parameter int DATA_BITS = 32,
  parameter int D         = 32,
  parameter int H         = 46,
  parameter int W         = 46,
  parameter int ADDR_BITS = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [ADDR_BITS-1:0] out_addr
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    OUT,
    DONE
  } state_t;

  // Upper-left corner of the last window in each dimension. Because of the
  // floor, an odd trailing row/column never becomes a window origin.
  localparam logic [ADDR_BITS-1:0] C_LAST = ADDR_BITS'(D - 1);
  localparam logic [ADDR_BITS-1:0] R_LAST = ADDR_BITS'(2 * (H / 2) - 2);
  localparam logic [ADDR_BITS-1:0] X_LAST = ADDR_BITS'(2 * (W / 2) - 2);
  localparam logic [ADDR_BITS-1:0] H_A    = ADDR_BITS'(H);
  localparam logic [ADDR_BITS-1:0] W_A    = ADDR_BITS'(W);

  state_t                       state_q;
  state_t                       state_d;
  logic [1:0]                   k_q;
  logic [ADDR_BITS-1:0]         c_q;
  logic [ADDR_BITS-1:0]         r_q;
  logic [ADDR_BITS-1:0]         x_q;
  logic [ADDR_BITS-1:0]         out_idx_q;
  logic signed [DATA_BITS-1:0]  acc_q;
  logic                         last_window;
  logic                         handshake;
  logic                         start_accept;
  logic                         capture;

  assign last_window  = (c_q == C_LAST) && (r_q == R_LAST) && (x_q == X_LAST);
  assign handshake    = (state_q == OUT) && out_ready;
  assign start_accept = (state_q == IDLE) && start;

  // Read data lags the strobe by one cycle, so the word for read k arrives
  // while k+1 is being issued. The k=3 word arrives in LAST.
  assign capture = ((state_q == READ) && (k_q != 2'd0)) || (state_q == LAST);

  // State register. An asynchronous reset drops straight to IDLE, which
  // abandons any pass in flight without producing a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. READ lasts four cycles (one per window element). LAST
  // waits for the final read word. OUT holds until downstream accepts, then
  // the scheduler either starts the next window or finishes the pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = READ;
      READ: if (k_q == 2'd3) state_d = LAST;
      LAST: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d = last_window ? DONE : READ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Traversal counters. The column pair is innermost, then the row pair, then
  // the channel. The pooled index simply counts accepted outputs, because the
  // traversal order matches the pooled output layout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      x_q       <= '0;
      out_idx_q <= '0;
    end else if (start_accept) begin
      k_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      x_q       <= '0;
      out_idx_q <= '0;
    end else begin
      if (state_q == READ) begin
        k_q <= k_q + 2'd1;
      end
      if (handshake && !last_window) begin
        out_idx_q <= out_idx_q + 1'b1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          if (r_q == R_LAST) begin
            r_q <= '0;
            c_q <= c_q + 1'b1;
          end else begin
            r_q <= r_q + ADDR_BITS'(2);
          end
        end else begin
          x_q <= x_q + ADDR_BITS'(2);
        end
      end
    end
  end

  // Running maximum. The first element of a window loads unconditionally, so
  // the previous window's result never leaks into the next one. Later
  // elements replace the value only when strictly greater, so a tie keeps the
  // earlier element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if ((state_q == READ) && (k_q == 2'd1)) begin
      acc_q <= $signed(rd_data);
    end else if (capture && ($signed(rd_data) > acc_q)) begin
      acc_q <= $signed(rd_data);
    end
  end

  // Read address for element k of the current window. k[1] selects the lower
  // row and k[0] selects the right column. The address is forced to zero
  // outside READ so that the SRAM bus stays quiet.
  always_comb begin
    rd_addr = '0;
    if (state_q == READ) begin
      rd_addr = (c_q * H_A + r_q + ADDR_BITS'(k_q[1])) * W_A
              + x_q + ADDR_BITS'(k_q[0]);
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_en     = (state_q == READ);
  assign out_valid = (state_q == OUT);
  assign out_data  = acc_q;
  assign out_addr  = out_idx_q;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// ---------------------------------------------------------------------------
// tb_maxpool_scheduler
//
// Drives three maxpool_scheduler instances with different geometries:
//   inst 0: D=1 H=2 W=2
//   inst 1: D=2 H=3 W=5 (odd trailing row and column)
//   inst 2: D=3 H=7 W=9 (odd trailing row and column)
// A behavioural model works out every expected read address and pooled
// maximum directly from the stored feature map. Directed scenarios add
// hand-computed literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_maxpool_scheduler;

  localparam int NI = 3;
  localparam int DB = 32;
  localparam int AB = 17;

  function automatic int cfg_d(int g);
    case (g)
      0: return 1;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_h(int g);
    case (g)
      0: return 2;
      1: return 3;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_w(int g);
    case (g)
      0: return 2;
      1: return 5;
      default: return 9;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start     [NI];
  logic          out_ready [NI];
  logic          busy      [NI];
  logic          done      [NI];
  logic          rd_en     [NI];
  logic          out_valid [NI];
  logic [AB-1:0] rd_addr   [NI];
  logic [AB-1:0] out_addr  [NI];
  logic [DB-1:0] rd_data   [NI];
  logic [DB-1:0] out_data  [NI];

  logic signed [DB-1:0] mem [NI][256];
  int                   ready_mode [NI];

  int checks   = 0;
  int failures = 0;

  // Model state, one entry per instance.
  bit                   m_busy     [NI];
  bit                   done_due   [NI];
  bit                   prev_stall [NI];
  int                   n_reads    [NI];
  int                   n_out      [NI];
  int                   dones      [NI];
  logic [DB-1:0]        prev_data  [NI];
  logic [AB-1:0]        prev_addr  [NI];
  logic signed [DB-1:0] last_data  [NI];

  always #5 clk = ~clk;

  // One design instance per geometry.
  for (genvar g = 0; g < NI; g++) begin : gen_dut
    maxpool_scheduler #(
      .DATA_BITS(DB),
      .D(cfg_d(g)),
      .H(cfg_h(g)),
      .W(cfg_w(g)),
      .ADDR_BITS(AB)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start[g]),
      .busy(busy[g]),
      .done(done[g]),
      .rd_en(rd_en[g]),
      .rd_addr(rd_addr[g]),
      .rd_data(rd_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data(out_data[g]),
      .out_addr(out_addr[g])
    );
  end

  // SRAM model with one-cycle read latency.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rd_en[g]) rd_data[g] <= mem[g][rd_addr[g][7:0]];
    end
  end

  // Downstream ready driver: mode 0 always ready, 1 random, 2 stalled.
  initial begin
    for (int g = 0; g < NI; g++) out_ready[g] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        case (ready_mode[g])
          0: out_ready[g] = 1'b1;
          1: out_ready[g] = 1'($urandom_range(0, 1));
          default: out_ready[g] = 1'b0;
        endcase
      end
    end
  end

  // Number of pooled outputs in one pass.
  function automatic int total(int g);
    return cfg_d(g) * (cfg_h(g) / 2) * (cfg_w(g) / 2);
  endfunction

  // Address of read n of a pass: window n/4, element n%4 in the order
  // (r,x), (r,x+1), (r+1,x), (r+1,x+1).
  function automatic int win_addr(int g, int n);
    int w, k, hp, wp, c, rem;
    w   = n / 4;
    k   = n % 4;
    hp  = cfg_h(g) / 2;
    wp  = cfg_w(g) / 2;
    c   = w / (hp * wp);
    rem = w % (hp * wp);
    return (c * cfg_h(g) + 2 * (rem / wp) + k / 2) * cfg_w(g) + 2 * (rem % wp) + k % 2;
  endfunction

  // Signed maximum of the four elements of window w.
  function automatic logic signed [DB-1:0] win_max(int g, int w);
    logic signed [DB-1:0] m, v;
    m = mem[g][win_addr(g, 4 * w) % 256];
    for (int k = 1; k < 4; k++) begin
      v = mem[g][win_addr(g, 4 * w + k) % 256];
      if (v > m) m = v;
    end
    return m;
  endfunction

  task automatic checkOutput(string name, int g, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s inst=%0d actual=%0d required=%0d t=%0t", name, g, act, exp, $time);
    end
  endtask

  // Compare process: checks every instance against the model on each cycle.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      bit nxt_due;
      if (!rst_n) begin
        checkOutput("reset_outputs", g,
                    longint'(busy[g] | done[g] | rd_en[g] | out_valid[g] |
                             (rd_addr[g] != 0) | (out_addr[g] != 0) | (out_data[g] != 0)), 0);
        m_busy[g]     = 0;
        done_due[g]   = 0;
        prev_stall[g] = 0;
        n_reads[g]    = 0;
        n_out[g]      = 0;
        continue;
      end
      checkOutput("busy", g, busy[g], m_busy[g]);
      checkOutput("done", g, done[g], done_due[g]);
      if (rd_en[g]) begin
        checkOutput("read_in_pass", g, longint'(m_busy[g] && (n_reads[g] < 4 * total(g))), 1);
        checkOutput("rd_addr", g, rd_addr[g], win_addr(g, n_reads[g]));
        checkOutput("rd_during_out", g, out_valid[g], 0);
        n_reads[g]++;
      end
      if (out_valid[g]) begin
        if (n_out[g] < total(g)) begin
          checkOutput("window_reads", g, n_reads[g], 4 * (n_out[g] + 1));
          checkOutput("out_addr", g, out_addr[g], n_out[g]);
          checkOutput("out_data", g, $signed(out_data[g]), win_max(g, n_out[g]));
        end else begin
          checkOutput("extra_output", g, 1, 0);
        end
      end
      if (prev_stall[g]) begin
        checkOutput("stall_valid", g, out_valid[g], 1);
        checkOutput("stall_data", g, out_data[g], prev_data[g]);
        checkOutput("stall_addr", g, out_addr[g], prev_addr[g]);
      end
      nxt_due = 0;
      if (out_valid[g] && out_ready[g]) begin
        n_out[g]++;
        last_data[g] = out_data[g];
        if (n_out[g] == total(g)) nxt_due = 1;
      end
      prev_stall[g] = out_valid[g] && !out_ready[g];
      prev_data[g]  = out_data[g];
      prev_addr[g]  = out_addr[g];
      if (done_due[g]) begin
        m_busy[g] = 0;
        dones[g]++;
      end else if (!m_busy[g] && start[g]) begin
        m_busy[g]  = 1;
        n_reads[g] = 0;
        n_out[g]   = 0;
      end
      done_due[g] = nxt_due;
    end
  end

  // Pulse start for one cycle; returns just after the edge that samples it.
  task automatic applyStimulus(int g);
    @(posedge clk);
    #1 start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
  endtask

  task automatic waitDone(int g, int budget);
    bit seen;
    seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = done[g];
    end
    checkOutput("pass_completes", g, seen, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic fillRandom(int g);
    for (int i = 0; i < 256; i++) mem[g][i] = $urandom();
    mem[g][3]  = 32'h8000_0000;
    mem[g][10] = 32'h7fff_ffff;
    mem[g][11] = 32'hffff_ffff;
  endtask

  // Watchdog in case a wait is ever left unbounded.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit            c_en   [9];
    bit            c_val  [9];
    bit            c_done [9];
    bit            c_busy [9];
    logic [AB-1:0] c_addr [9];
    logic [DB-1:0] c_data [9];
    logic [AB-1:0] c_oaddr[9];
    int            d_before;
    bit            seen;

    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start[g]      = 1'b0;
      ready_mode[g] = 0;
      dones[g]      = 0;
      fillRandom(g);
    end
    #23 rst_n = 1'b1;

    // Scenario 1: single window, exact cycle timing.
    $display("[TB] single window timing");
    mem[0][0] = 3; mem[0][1] = -5; mem[0][2] = 7; mem[0][3] = 1;
    checkOutput("model_pin_max7", 0, win_max(0, 0), 7);
    applyStimulus(0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      c_en[cyc]    = rd_en[0];
      c_addr[cyc]  = rd_addr[0];
      c_val[cyc]   = out_valid[0];
      c_data[cyc]  = out_data[0];
      c_oaddr[cyc] = out_addr[0];
      c_done[cyc]  = done[0];
      c_busy[cyc]  = busy[0];
    end
    for (int cyc = 1; cyc <= 4; cyc++) begin
      checkOutput("t1_rd_en", 0, c_en[cyc], 1);
      checkOutput("t1_rd_addr", 0, c_addr[cyc], cyc - 1);
    end
    checkOutput("t1_last_rd_en", 0, c_en[5], 0);
    checkOutput("t1_last_valid", 0, c_val[5], 0);
    checkOutput("t1_valid6", 0, c_val[6], 1);
    checkOutput("t1_data6", 0, $signed(c_data[6]), 7);
    checkOutput("t1_addr6", 0, c_oaddr[6], 0);
    checkOutput("t1_done7", 0, c_done[7], 1);
    checkOutput("t1_busy7", 0, c_busy[7], 1);
    checkOutput("t1_valid7", 0, c_val[7], 0);
    checkOutput("t1_busy8", 0, c_busy[8], 0);
    checkOutput("t1_done8", 0, c_done[8], 0);
    #1 checkOutput("t1_done_count", 0, dones[0], 1);

    // Scenario 2: signed compare and ties.
    $display("[TB] signed max and ties");
    mem[0][0] = -8; mem[0][1] = -2; mem[0][2] = -9; mem[0][3] = -3;
    checkOutput("model_pin_neg", 0, win_max(0, 0), -2);
    applyStimulus(0);
    waitDone(0, 20);
    checkOutput("t2_signed_max", 0, last_data[0], -2);
    for (int i = 0; i < 4; i++) mem[0][i] = 5;
    applyStimulus(0);
    waitDone(0, 20);
    checkOutput("t2_tie_max", 0, last_data[0], 5);

    // Scenario 3: ten cycles of backpressure on the first window.
    $display("[TB] backpressure");
    ready_mode[2] = 2;
    applyStimulus(2);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid[2];
    end
    checkOutput("t3_first_valid", 2, seen, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("t3_hold_valid", 2, out_valid[2], 1);
      checkOutput("t3_hold_rd_en", 2, rd_en[2], 0);
      checkOutput("t3_hold_addr", 2, out_addr[2], 0);
    end
    ready_mode[2] = 0;
    waitDone(2, 1000);
    checkOutput("t3_outputs", 2, n_out[2], 36);

    // Scenario 4: random data with random downstream ready.
    $display("[TB] random data, random ready");
    fillRandom(2);
    for (int i = 100; i < 189; i++) mem[2][i] = $urandom();
    ready_mode[2] = 1;
    d_before = dones[2];
    applyStimulus(2);
    waitDone(2, 3000);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t4_outputs", 2, n_out[2], 36);
    checkOutput("t4_done_once", 2, dones[2] - d_before, 1);
    checkOutput("t4_busy_after", 2, busy[2], 0);
    ready_mode[2] = 0;

    // Scenario 5: odd geometry; trailing row and column are never read.
    $display("[TB] odd geometry");
    checkOutput("model_pin_addr", 1, win_addr(1, 15), 23);
    applyStimulus(1);
    waitDone(1, 200);
    checkOutput("t5_outputs", 1, n_out[1], 4);
    checkOutput("t5_reads", 1, n_reads[1], 16);

    // Scenario 6: mid-pass start is ignored; mid-window reset aborts the pass.
    $display("[TB] mid-pass start and reset");
    applyStimulus(2);
    repeat (8) @(negedge clk);
    applyStimulus(2);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = rd_en[2];
    end
    checkOutput("t6_in_window", 2, seen, 1);
    d_before = dones[2];
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_busy", 2, busy[2], 0);
    checkOutput("t6_async_rd_en", 2, rd_en[2], 0);
    checkOutput("t6_async_rd_addr", 2, rd_addr[2], 0);
    checkOutput("t6_async_data", 2, out_data[2], 0);
    checkOutput("t6_async_oaddr", 2, out_addr[2], 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1 checkOutput("t6_no_done", 2, dones[2] - d_before, 0);
    applyStimulus(2);
    waitDone(2, 1000);
    checkOutput("t6_outputs", 2, n_out[2], 36);
    checkOutput("t6_done_once", 2, dones[2] - d_before, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
